// File: rtl/pu_riscv_pkg.sv
// -----------------------------------------------------------------------------
// pu_riscv_pkg
//   Shared AMBA3 AHB-Lite encodings used by the RISC-V bus interface units.
//   No ports; imported with "import pu_riscv_pkg::*;".
// -----------------------------------------------------------------------------
package pu_riscv_pkg;

    // HTRANS encodings
    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_BUSY   = 2'b01;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

    // HBURST encodings (only SINGLE is ever issued)
    localparam logic [2:0] HBURST_SINGLE = 3'b000;

    // HSIZE encodings
    localparam logic [2:0] HSIZE_BYTE  = 3'b000;
    localparam logic [2:0] HSIZE_HWORD = 3'b001;
    localparam logic [2:0] HSIZE_WORD  = 3'b010;
    localparam logic [2:0] HSIZE_DWORD = 3'b011;

    // HRESP encodings
    localparam logic HRESP_OKAY  = 1'b0;
    localparam logic HRESP_ERROR = 1'b1;

endpackage : pu_riscv_pkg

// File: rtl/pu_riscv_biu_ahb3.sv
// -----------------------------------------------------------------------------
// pu_riscv_biu_ahb3
//   Bus interface unit between the memory access buffer and one AMBA3
//   AHB-Lite master port. Issues SINGLE transfers with pipelined address and
//   data phases (one transfer per cycle back-to-back) and reports completion,
//   error status and read data to the memory stage.
//
//   Request handshake: req_i is a valid that is held with stable fields until
//   ack_o; ack_o is combinational and a request is consumed on every rising
//   clk_i edge where req_i & ack_o. ack_o never depends on anything the
//   requester computes from ack_o itself.
//
// Ports
//   clk_i, rst_ni          clock, asynchronous active-low reset
//   clr_i                  flush: cancel retry/idle the bus, hide completions
//   req_i ... wd_i         request valid and payload from the buffer
//   ack_o                  request accepted this cycle
//   done_o, err_o, q_o     completion pulse, error qualifier, read data
//   H*                     AHB-Lite master port (all outputs registered)
// -----------------------------------------------------------------------------
module pu_riscv_biu_ahb3
    import pu_riscv_pkg::*;
#(
    parameter int XLEN = 64,
    parameter int PLEN = 64
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic            clr_i,

    input  logic            req_i,
    input  logic [PLEN-1:0] adr_i,
    input  logic            we_i,
    input  logic [2:0]      size_i,
    input  logic [3:0]      prot_i,
    input  logic            lock_i,
    input  logic [XLEN-1:0] wd_i,
    output logic            ack_o,

    output logic            done_o,
    output logic            err_o,
    output logic [XLEN-1:0] q_o,

    output logic            HSEL,
    output logic [PLEN-1:0] HADDR,
    output logic [XLEN-1:0] HWDATA,
    input  logic [XLEN-1:0] HRDATA,
    output logic            HWRITE,
    output logic [2:0]      HSIZE,
    output logic [2:0]      HBURST,
    output logic [3:0]      HPROT,
    output logic [1:0]      HTRANS,
    output logic            HMASTLOCK,
    input  logic            HREADY,
    input  logic            HRESP
);

    // Data-phase bookkeeping
    logic            dph_valid;   // a transfer is in its data phase
    logic            dph_we;      // that transfer is a write
    logic            dph_kill;    // its completion must not be reported
    logic            retry;       // address phase was cancelled by an ERROR
    logic [XLEN-1:0] wd_hold;     // write data waiting for its data phase
    logic            err1;        // first cycle of a two-cycle ERROR response
    logic            addr_nonseq; // current address phase carries a transfer

    assign err1        = HRESP & ~HREADY & dph_valid;
    assign addr_nonseq = (HTRANS == HTRANS_NONSEQ);
    assign ack_o       = req_i & HREADY & ~retry & ~clr_i & ~err1;

    // -------------------------------------------------------------------------
    // Address phase. The address/control fields only change on a new accept,
    // so after an ERROR they still describe the cancelled request and can be
    // re-issued unchanged.
    // -------------------------------------------------------------------------
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            HTRANS    <= HTRANS_IDLE;
            HSEL      <= 1'b0;
            HADDR     <= '0;
            HWRITE    <= 1'b0;
            HSIZE     <= HSIZE_BYTE;
            HBURST    <= HBURST_SINGLE;
            HPROT     <= '0;
            HMASTLOCK <= 1'b0;
            wd_hold   <= '0;
            retry     <= 1'b0;
        end else if (HREADY) begin
            if (ack_o) begin
                HTRANS    <= HTRANS_NONSEQ;
                HSEL      <= 1'b1;
                HADDR     <= adr_i;
                HWRITE    <= we_i;
                HSIZE     <= size_i;
                HBURST    <= HBURST_SINGLE;
                HPROT     <= prot_i;
                HMASTLOCK <= lock_i;
                wd_hold   <= wd_i;
                retry     <= 1'b0;
            end else if (retry && !clr_i) begin
                // Re-issue the request that the ERROR response cancelled.
                HTRANS <= HTRANS_NONSEQ;
                HSEL   <= 1'b1;
                retry  <= 1'b0;
            end else begin
                HTRANS <= HTRANS_IDLE;
                HSEL   <= 1'b0;
                retry  <= 1'b0;
            end
        end else if (err1 && addr_nonseq) begin
            // AHB-Lite lets the master drop a pipelined transfer to IDLE in
            // the first ERROR cycle; it has already been acked, so remember
            // to send it again.
            HTRANS <= HTRANS_IDLE;
            retry  <= 1'b1;
        end
    end

    // -------------------------------------------------------------------------
    // Data phase and completion reporting.
    // -------------------------------------------------------------------------
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            dph_valid <= 1'b0;
            dph_we    <= 1'b0;
            dph_kill  <= 1'b0;
            HWDATA    <= '0;
            done_o    <= 1'b0;
            err_o     <= 1'b0;
            q_o       <= '0;
        end else begin
            done_o <= 1'b0;
            err_o  <= 1'b0;
            if (HREADY) begin
                dph_valid <= addr_nonseq;
                if (addr_nonseq) begin
                    dph_we   <= HWRITE;
                    HWDATA   <= wd_hold;
                    dph_kill <= clr_i;
                end
                if (dph_valid) begin
                    // A flush coinciding with the last data-phase cycle also
                    // hides that completion.
                    done_o <= ~(dph_kill | clr_i);
                    err_o  <= HRESP & ~(dph_kill | clr_i);
                    if (!dph_we) begin
                        q_o <= HRDATA;
                    end
                end
            end else if (clr_i && dph_valid) begin
                // Flush during a wait state: the bus still finishes the
                // transfer but nobody is waiting for its result.
                dph_kill <= 1'b1;
            end
        end
    end

endmodule : pu_riscv_biu_ahb3
